// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder/subtractor controller.
//
// Accepts an operation on start, then runs every result bit through a single
// full adder, LSB first, one bit per clock. Subtraction is done as
// a + ~b + 1 by inverting b on load and seeding the carry with 1.
//
// Ports:
//   clk        system clock, rising edge active
//   reset      asynchronous, active-high reset
//   start      request a new operation (accepted only in IDLE)
//   sub        0 = a+b, 1 = a-b; sampled with start
//   a, b       operands; sampled with start
//   busy       high while an operation is in progress (RUN and DONE)
//   done       one-cycle pulse, result valid
//   sum        result (driven directly by the result shift register)
//   carry_out  carry out of the MSB (for subtraction 1 = no borrow)
//   overflow   two's-complement signed overflow

// full_adder -- single-bit full adder.
// Ports: a, b, carry_in -> sum, carry_out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);
endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result outputs hold their last values
// RUN   | one bit per cycle through the full adder, WIDTH cycles
// DONE  | single cycle with done=1, then back to IDLE unconditionally
module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;

    // The only adder in the block; every result bit comes through here.
    full_adder u_fa (
        .sum       (fa_sum),
        .carry_out (fa_cout),
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (carry)
    );

    assign sum = res_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Bits enter at the MSB so that after WIDTH shifts the
                    // first computed bit sits at bit 0.
                    res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Signed overflow: carry into the MSB differs from
                        // carry out of it.
                        overflow  <= carry ^ fa_cout;
                        carry_out <= fa_cout;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int vectors = 0;
    int miscompares = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] rs, output logic rc, output logic rv);
        longint sx, sy, r;
        logic [W:0] wide;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = s ? (sx - sy) : (sx + sy);
        rv = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (s) begin
            rs = x - y;
            rc = (x >= y);
        end else begin
            wide = {1'b0, x} + {1'b0, y};
            rs = wide[W-1:0];
            rc = wide[W];
        end
    endtask

    // Called at a negedge; start is seen by the following rising edge.
    task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        sub   = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Called at the negedge after acceptance. Returns at the done negedge.
    // With inject set, start is pulsed mid-run and raised again in the done cycle.
    task automatic wait_result(input string tag, input logic s, input logic [W-1:0] x,
                               input logic [W-1:0] y, input bit inject);
        logic [W-1:0] es;
        logic ec, ev;
        int cycles, busy_n;
        model(s, x, y, es, ec, ev);
        cycles = 1;
        busy_n = busy ? 1 : 0;
        while (!done && cycles < W + 10) begin
            if (inject) begin
                start = (cycles == 5) || (cycles == 6);
                sub   = 1'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            @(negedge clk);
            cycles++;
            if (busy) busy_n++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_latency"}, cycles, W + 1);
        check({tag, "_busy_cycles"}, busy_n, W + 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, ev);
        if (inject) begin
            start = 1'b1;
            a     = $urandom;
            b     = $urandom;
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic idle_hold(input string tag, input logic s, input logic [W-1:0] x,
                             input logic [W-1:0] y);
        logic [W-1:0] es;
        logic ec, ev;
        model(s, x, y, es, ec, ev);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
        check({tag, "_idle_done"}, done, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_hold_sum"}, sum, es);
        check({tag, "_hold_cout"}, carry_out, ec);
        check({tag, "_hold_ovf"}, overflow, ev);
    endtask

    task automatic op(input string tag, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        launch(s, x, y);
        wait_result(tag, s, x, y, 1'b0);
        idle_hold(tag, s, x, y);
    endtask

    initial begin
        logic [W-1:0] nx, ny;
        logic ns;
        int done_seen;

        // Power-on reset, then first start on the first edge after release.
        #2;
        check("por_busy", busy, 1'b0);
        check("por_sum", sum, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        op("add_5_3", 1'b0, 32'd5, 32'd3);

        // Reset pulse mid-idle clears results without a clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_idle_busy", busy, 1'b0);
        check("rst_idle_done", done, 1'b0);
        check("rst_idle_sum", sum, '0);
        check("rst_idle_cout", carry_out, 1'b0);
        check("rst_idle_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        op("sub_5_7", 1'b1, 32'd5, 32'd7);
        op("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001);
        op("sub_zero", 1'b1, 32'h1234_5678, 32'h0000_0000);

        // start during RUN and in the done cycle is ignored; the cycle after
        // done accepts a new operation.
        launch(1'b0, 32'd100, 32'd23);
        wait_result("inj", 1'b0, 32'd100, 32'd23, 1'b1);
        @(negedge clk);
        check("inj_done_start_ignored", busy, 1'b0);
        check("inj_done_low", done, 1'b0);
        ns = 1'b1;
        nx = 32'hDEAD_BEEF;
        ny = 32'h0BAD_F00D;
        launch(ns, nx, ny);
        wait_result("b2b", ns, nx, ny, 1'b0);
        idle_hold("b2b", ns, nx, ny);

        // Reset 10 cycles into RUN: immediate IDLE, no done pulse.
        launch(1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        repeat (9) @(negedge clk);
        check("mid_run_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_run_busy", busy, 1'b0);
        check("rst_run_done", done, 1'b0);
        check("rst_run_sum", sum, '0);
        check("rst_run_cout", carry_out, 1'b0);
        check("rst_run_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("rst_run_no_done", done_seen, 0);
        op("after_rst", 1'b0, 32'd5, 32'd3);

        // Randomised operations.
        for (int i = 0; i < 20; i++) begin
            ns = 1'($urandom);
            nx = $urandom;
            ny = $urandom;
            if (i % 5 == 0) ny = nx;
            op("rand", ns, nx, ny);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits (legal range 2..64).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new operation; sampled on the rising edge of clk.
REQ-005 Port: sub  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 Port: a  input  WIDTH  first operand; sampled with start.
REQ-007 Port: b  input  WIDTH  second operand; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking that the result is valid.
REQ-010 Port: sum  output  WIDTH  result, least significant bit is bit 0.
REQ-011 Port: carry_out  output  1  carry out of the MSB; for subtraction, 1 = no borrow.
REQ-012 Port: overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-013 The block SHALL instantiate exactly one full_adder (ports: sum, carry_out, a, b, carry_in) and SHALL compute every result bit through that single instance, one bit per clock cycle.
REQ-014 FSM states SHALL be IDLE, RUN and DONE; the reset state is IDLE.
REQ-015 IDLE: start=1 SHALL be accepted on that edge, with these loads:
  - operand shift register A = a;
  - operand shift register B = (sub ? ~b : b);
  - carry register = sub;
  - bit counter = 0;
  - next state = RUN.
REQ-016 IDLE with start=0 SHALL hold state; sum, carry_out and overflow SHALL hold their previous values.
REQ-017 RUN, each cycle:
  - full_adder inputs SHALL be A[0], B[0] and the carry register;
  - the full_adder sum SHALL be shifted into the result register at the MSB end;
  - A and B SHALL shift right by one;
  - the carry register SHALL take the full_adder carry_out;
  - the counter SHALL increment.
REQ-018 The cycle that processes bit WIDTH-1 SHALL also capture:
  - overflow = carry_in(bit WIDTH-1) XOR carry_out(bit WIDTH-1);
  - carry_out = the final full_adder carry;
  - next state = DONE.
REQ-019 The RUN state SHALL last exactly WIDTH cycles.
REQ-020 DONE SHALL last exactly one cycle, with done=1, and SHALL then return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance.
REQ-023 start SHALL be ignored in RUN and DONE; an accepted operation SHALL never be aborted or restarted by start.
REQ-024 a, b and sub SHALL be don't-care after acceptance; changes to them SHALL NOT affect the operation in progress.
REQ-025 sum, carry_out and overflow SHALL be stable and valid from the done cycle until the next accepted start; the result register drives sum directly.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; there SHALL be no saturation.
REQ-027 start arriving in the same cycle as done SHALL be ignored; the earliest back-to-back acceptance is the cycle following done.

Reset
REQ-028 On reset=1, independent of clk, the block SHALL go to IDLE and SHALL clear:
  - busy = 0 and done = 0;
  - sum = 0, carry_out = 0, overflow = 0;
  - the counter, shift registers and carry register.
REQ-029 Reset asserted during RUN or DONE SHALL discard the operation with no done pulse.
REQ-030 The first start SHALL be accepted on the first rising edge after reset is released.

Verification (WIDTH=32)
REQ-031 reset pulse mid-idle -> all outputs 0, busy=0.
REQ-032 start, sub=0, a=5, b=3 -> done exactly 33 cycles after acceptance; sum=0x00000008, carry_out=0, overflow=0; busy high for 33 cycles.
REQ-033 add a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, carry_out=1, overflow=0; then add a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, carry_out=0, overflow=1.
REQ-034 sub=1, a=5, b=7 -> sum=0xFFFFFFFE, carry_out=0, overflow=0; then sub a=0x80000000, b=1 -> sum=0x7FFFFFFF, carry_out=1, overflow=1.
REQ-035 start re-asserted with different a/b during RUN and in the done cycle -> ignored; the original result is delivered; a start on the cycle after done is accepted.
REQ-036 reset asserted 10 cycles into RUN -> immediate IDLE, outputs 0, no done pulse; a subsequent start for 5+3 completes normally with sum=8.
